// File: rtl/alu_if_pkg.sv
// Shared definitions for the ALU execute-stage result interface:
// result word width, field bit positions and the commit-type encoding.
package alu_if_pkg;

  localparam int RES_W  = 74;

  localparam int CMT_HI = 73;
  localparam int CMT_LO = 72;
  localparam int RES_HI = 71;
  localparam int RES_LO = 40;
  localparam int DAT_HI = 39;
  localparam int DAT_LO = 8;
  localparam int FLG_HI = 7;
  localparam int FLG_LO = 0;

  typedef enum logic [1:0] {
    CMT_REGULAR = 2'd0,
    CMT_MEMORY  = 2'd1,
    CMT_SYSTEM  = 2'd2,
    CMT_TRAP    = 2'd3
  } cmt_e;

endpackage

// File: rtl/alu_result_fifo.sv
// Circular-buffer FIFO for ALU results. The caller qualifies push/pop;
// clr empties the buffer and has priority over both.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 74
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic [$clog2(DEPTH):0]   occ_nxt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap for free.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i && !clr_i) mem_q[wr_q] <= data_i;
  end

  assign head_o    = mem_q[rd_q];
  assign occ_o     = cnt_q;
  assign occ_nxt_o = cnt_d;

endmodule

// File: rtl/alu_result_sink.sv
// Receives ALU results, buffers them and hands them to writeback; throttles
// the ALU through a registered issue permit and discards post-flush stragglers.
module alu_result_sink #(
  parameter int DEPTH = 4,
  parameter int RES_W = 74
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [RES_W-1:0]       alu_result,
  input  logic                   alu_valid,
  output logic                   alu_issue_ok,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [1:0]             wb_cmtype,
  output logic [31:0]            wb_result,
  output logic [31:0]            wb_data,
  output logic [7:0]             wb_flags,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err
);

  import alu_if_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic             push, pop, full;
  logic             drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             ok_q, ok_d;
  logic [RES_W-1:0] head;
  logic [CW-1:0]    occ, occ_nxt;

  assign full = (occ == CW'(DEPTH));
  assign pop  = wb_valid & wb_ready & ~flush;
  assign push = alu_valid & ~flush & ~drop_q & (~full | pop);

  // A result arriving right after a flush was issued before it, so drop it.
  assign drop_d = flush;
  assign ovf_d  = ovf_q | (alu_valid & ~flush & ~drop_q & full & ~pop);
  // Registered from next occupancy, so the permit reflects state only.
  assign ok_d   = (occ_nxt <= CW'(DEPTH - 2));

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      ok_q   <= ok_d;
    end
  end

  alu_result_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push_i    (push),
    .pop_i     (pop),
    .clr_i     (flush),
    .data_i    (alu_result),
    .head_o    (head),
    .occ_o     (occ),
    .occ_nxt_o (occ_nxt)
  );

  assign wb_valid     = (occ != '0);
  assign wb_cmtype    = head[CMT_HI:CMT_LO];
  assign wb_result    = head[RES_HI:RES_LO];
  assign wb_data      = head[DAT_HI:DAT_LO];
  assign wb_flags     = head[FLG_HI:FLG_LO];
  assign occupancy    = occ;
  assign overflow_err = ovf_q;
  assign alu_issue_ok = ok_q;

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed test of alu_result_sink (DEPTH=4): latency, fill/overflow,
// full push+pop with wrap, flush/drop window and asynchronous reset.
module tb_alu_result_sink;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [73:0] alu_result;
  logic        alu_valid, flush, wb_ready;
  logic        alu_issue_ok, wb_valid, overflow_err;
  logic [1:0]  wb_cmtype;
  logic [31:0] wb_result, wb_data;
  logic [7:0]  wb_flags;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_result_sink #(.DEPTH(4), .RES_W(74)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .alu_result   (alu_result),
    .alu_valid    (alu_valid),
    .alu_issue_ok (alu_issue_ok),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_cmtype    (wb_cmtype),
    .wb_result    (wb_result),
    .wb_data      (wb_data),
    .wb_flags     (wb_flags),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [73:0] mk(logic [1:0] c, logic [31:0] r, logic [31:0] d, logic [7:0] f);
    return {c, r, d, f};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tag(logic [7:0] t);
    alu_valid  = 1'b1;
    alu_result = mk(2'd0, 32'(t) << 4, ~32'(t), t);
    step();
  endtask

  task automatic do_reset();
    RST_N = 1'b1;
    step();
    RST_N = 1'b0;
    step();
  endtask

  initial begin
    RST_N = 1'b1; alu_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0; alu_result = '0;
    #1;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_wbv", 32'(wb_valid), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_ok", 32'(alu_issue_ok), 0);
    step();
    RST_N = 1'b0;
    step();
    chk("rel_ok", 32'(alu_issue_ok), 1);

    // Single result, no bypass: visible only after the accepting edge.
    alu_valid = 1'b1; wb_ready = 1'b1;
    alu_result = mk(2'd1, 32'h0000_1000, 32'hDEAD_BEEF, 8'h00);
    chk("single_nobypass", 32'(wb_valid), 0);
    step();
    alu_valid = 1'b0;
    chk("single_wbv", 32'(wb_valid), 1);
    chk("single_cmt", 32'(wb_cmtype), 1);
    chk("single_res", wb_result, 32'h0000_1000);
    chk("single_dat", wb_data, 32'hDEAD_BEEF);
    chk("single_flg", 32'(wb_flags), 0);
    chk("single_occ", 32'(occupancy), 1);
    step();
    chk("single_empty", 32'(wb_valid), 0);
    chk("single_occ0", 32'(occupancy), 0);

    // Fill with writeback stalled, then overflow.
    wb_ready = 1'b0;
    push_tag(8'd1); chk("fill1_ok", 32'(alu_issue_ok), 1);
    push_tag(8'd2); chk("fill2_ok", 32'(alu_issue_ok), 1);
    push_tag(8'd3); chk("fill3_ok", 32'(alu_issue_ok), 0);
    chk("fill3_occ", 32'(occupancy), 3);
    push_tag(8'd4); chk("fill4_occ", 32'(occupancy), 4);
    chk("fill4_ovf", 32'(overflow_err), 0);
    push_tag(8'd5); chk("ovf_occ", 32'(occupancy), 4);
    chk("ovf_set", 32'(overflow_err), 1);
    alu_valid = 1'b0; wb_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_tag%0d", k), 32'(wb_flags), 32'(k));
      chk($sformatf("drain_res%0d", k), wb_result, 32'(k) << 4);
      step();
    end
    chk("drain_empty", 32'(wb_valid), 0);
    chk("ovf_sticky", 32'(overflow_err), 1);

    // Full with simultaneous push and pop, past pointer wrap.
    do_reset();
    chk("rst2_ovf", 32'(overflow_err), 0);
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_tag(8'(10 + k));
    chk("full_occ", 32'(occupancy), 4);
    for (int k = 0; k < 6; k++) begin
      wb_ready = 1'b1;
      chk($sformatf("pp_head%0d", k), 32'(wb_flags), 32'(10 + k));
      push_tag(8'(14 + k));
      chk($sformatf("pp_occ%0d", k), 32'(occupancy), 4);
    end
    alu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_tag%0d", k), 32'(wb_flags), 32'(16 + k));
      chk($sformatf("wrap_dat%0d", k), wb_data, ~32'(16 + k));
      step();
    end
    chk("wrap_empty", 32'(occupancy), 0);
    chk("wrap_ovf", 32'(overflow_err), 0);

    // Flush with a concurrent valid, then the one-cycle drop window.
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_tag(8'(30 + k));
    chk("pre_flush_occ", 32'(occupancy), 3);
    flush = 1'b1; wb_ready = 1'b1;
    push_tag(8'd39);
    flush = 1'b0; wb_ready = 1'b0;
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_wbv", 32'(wb_valid), 0);
    chk("flush_ok", 32'(alu_issue_ok), 1);
    push_tag(8'd40); chk("drop_occ", 32'(occupancy), 0);
    push_tag(8'd41); chk("post_drop_occ", 32'(occupancy), 1);
    chk("post_drop_tag", 32'(wb_flags), 41);

    // Back-to-back flushes extend the drop window.
    alu_valid = 1'b0; flush = 1'b1;
    step();
    push_tag(8'd42);
    flush = 1'b0;
    chk("flush2_occ", 32'(occupancy), 0);
    push_tag(8'd43); chk("drop2_occ", 32'(occupancy), 0);
    push_tag(8'd44); chk("accept2_occ", 32'(occupancy), 1);
    chk("accept2_tag", 32'(wb_flags), 44);

    // Asynchronous reset in the middle of a cycle.
    push_tag(8'd45);
    alu_valid = 1'b0;
    chk("mid_occ", 32'(occupancy), 2);
    #3 RST_N = 1'b1;
    #1;
    chk("async_occ", 32'(occupancy), 0);
    chk("async_wbv", 32'(wb_valid), 0);
    chk("async_ok", 32'(alu_issue_ok), 0);
    #2 RST_N = 1'b0;
    alu_result = mk(2'd3, 32'hCAFE_0050, 32'h0000_0004, 8'd50);
    alu_valid = 1'b1; wb_ready = 1'b1;
    step();
    alu_valid = 1'b0;
    chk("rel2_ok", 32'(alu_issue_ok), 1);
    chk("rel2_ovf", 32'(overflow_err), 0);
    chk("rel2_wbv", 32'(wb_valid), 1);
    chk("rel2_cmt", 32'(wb_cmtype), 3);
    chk("rel2_res", wb_result, 32'hCAFE_0050);
    step();
    chk("rel2_empty", 32'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
